// File: rtl/dmem_bus.sv
// dmem_bus: byte/half/word MIPS data memory with a REQ/ACK handshake and optional wait states.
// Accesses are serialised. Each one executes at its accept edge, or WAIT_CYCLES edges after it.
module dmem_bus #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ,
  input  logic              WE,
  input  logic [1:0]        SIZE,
  input  logic              SIGNED,
  input  logic [ADDR_W-1:0] ADR,
  input  logic [31:0]       WDATA,
  output logic              ACK,
  output logic [31:0]       RDATA,
  output logic              ERR,
  output logic              BUSY
);
  localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              ack_q, err_q, busy_q;
  logic [31:0]       rdata_q;
  logic              we_q, sgn_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       wdata_q;

  logic [31:0] mem [DEPTH];

  logic              exec_d, e_we, e_sgn;
  logic [1:0]        e_size;
  logic [ADDR_W-1:0] e_adr;
  logic [31:0]       e_wdata;

  // With no wait states the access runs straight off the bus inputs at the accept edge.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      exec_d  = REQ && (state_q == IDLE);
      e_we    = WE;
      e_size  = SIZE;
      e_sgn   = SIGNED;
      e_adr   = ADR;
      e_wdata = WDATA;
    end else begin
      exec_d  = (state_q == WAIT) && (cnt_q == 4'd0);
      e_we    = we_q;
      e_size  = size_q;
      e_sgn   = sgn_q;
      e_adr   = adr_q;
      e_wdata = wdata_q;
    end
  end

  logic [IW-1:0] widx;
  logic          range_err, err_d, wr_d;
  logic [31:0]   rword, sh_d, ld_d, wd_d;
  logic [NUM_LANES-1:0] be_d;

  assign widx      = e_adr[IW+1:2];
  assign range_err = 64'(e_adr[ADDR_W-1:2]) >= 64'(DEPTH);
  assign err_d     = (e_size == 2'b11) || ((e_size == 2'b01) && e_adr[0]) ||
                     ((e_size == 2'b10) && (e_adr[1:0] != 2'b00)) || range_err;
  assign wr_d      = exec_d && e_we && !err_d;
  assign rword     = mem[widx];

  always_comb begin
    sh_d = rword >> {e_adr[1:0], 3'b000};
    case (e_size)
      2'b00:   ld_d = {{24{e_sgn & sh_d[7]}}, sh_d[7:0]};
      2'b01:   ld_d = {{16{e_sgn & sh_d[15]}}, sh_d[15:0]};
      default: ld_d = rword;
    endcase
  end

  // Store data is replicated across lanes so each byte enable just picks its own slice.
  always_comb begin
    be_d = '0;
    wd_d = e_wdata;
    case (e_size)
      2'b00: begin
        be_d[e_adr[1:0]] = 1'b1;
        wd_d = {4{e_wdata[7:0]}};
      end
      2'b01: begin
        be_d = e_adr[1] ? 4'b1100 : 4'b0011;
        wd_d = {2{e_wdata[15:0]}};
      end
      2'b10:   be_d = 4'b1111;
      default: be_d = '0;
    endcase
  end

  always_ff @(posedge CLK)
    for (int l = 0; l < NUM_LANES; l++)
      if (wr_d && be_d[l]) mem[widx][8*l +: 8] <= wd_d[8*l +: 8];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
    end else begin
      ack_q <= exec_d;
      err_q <= exec_d && err_d;
      if (exec_d) rdata_q <= (e_we || err_d) ? 32'd0 : ld_d;
      case (state_q)
        IDLE: if (REQ) begin
          we_q    <= WE;
          size_q  <= SIZE;
          sgn_q   <= SIGNED;
          adr_q   <= ADR;
          wdata_q <= WDATA;
          if (WAIT_CYCLES != 0) begin
            state_q <= WAIT;
            cnt_q   <= 4'(WAIT_CYCLES - 1);
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ACK   = ack_q;
  assign ERR   = err_q;
  assign RDATA = rdata_q;
  assign BUSY  = busy_q;
endmodule

// File: tb/tb_dmem_bus.sv
// Bench for dmem_bus: one zero-wait instance and one three-wait instance, each with its own
// byte-addressed reference memory.
module tb_dmem_bus;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 64;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst0_n, req0, we0, sg0, ack0, err0, busy0;
  logic [1:0] sz0;
  logic [ADDR_W-1:0] adr0;
  logic [31:0] wd0, rd0;
  logic rst3_n, req3, we3, sg3, ack3, err3, busy3;
  logic [1:0] sz3;
  logic [ADDR_W-1:0] adr3;
  logic [31:0] wd3, rd3;

  int checks = 0;
  int failures = 0;
  logic [7:0] mb [2][4*DEPTH];

  dmem_bus #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u0 (
    .CLK(CLK), .RST_N(rst0_n), .REQ(req0), .WE(we0), .SIZE(sz0), .SIGNED(sg0), .ADR(adr0),
    .WDATA(wd0), .ACK(ack0), .RDATA(rd0), .ERR(err0), .BUSY(busy0));

  dmem_bus #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u3 (
    .CLK(CLK), .RST_N(rst3_n), .REQ(req3), .WE(we3), .SIZE(sz3), .SIGNED(sg3), .ADR(adr3),
    .WDATA(wd3), .ACK(ack3), .RDATA(rd3), .ERR(err3), .BUSY(busy3));

  // Reference: memory as a flat byte array, access width 1<<SIZE bytes, little-endian.
  function automatic void model(input int d, input bit we, input logic [1:0] sz, input bit sg,
                                input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                                output bit err, output logic [31:0] rd);
    int ai = int'(a);
    int n = 1 << sz;
    logic [31:0] v = 32'd0;
    err = (sz == 2'b11) || (ai % n != 0) || (ai / 4 >= DEPTH);
    rd = 32'd0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) mb[d][ai+i] = wd[8*i +: 8];
      return;
    end
    for (int i = 0; i < n; i++) v = v | (32'(mb[d][ai+i]) << (8*i));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
    rd = v;
  endfunction

  task automatic acc0(input bit we, input logic [1:0] sz, input bit sg, input logic [ADDR_W-1:0] a,
                      input logic [31:0] wd, output logic o_ack, output logic o_err,
                      output logic [31:0] o_rd, output bit e_err, output logic [31:0] e_rd);
    req0 = 1'b1; we0 = we; sz0 = sz; sg0 = sg; adr0 = a; wd0 = wd;
    model(0, we, sz, sg, a, wd, e_err, e_rd);
    @(posedge CLK); #1;
    o_ack = ack0; o_err = err0; o_rd = rd0;
  endtask

  task automatic idle0(output logic o_ack);
    req0 = 1'b0;
    @(posedge CLK); #1;
    o_ack = ack0;
  endtask

  task automatic acc3(input bit we, input logic [1:0] sz, input bit sg, input logic [ADDR_W-1:0] a,
                      input logic [31:0] wd, input bit pulse, input logic [ADDR_W-1:0] pa,
                      output logic o_ack, output logic o_err, output logic [31:0] o_rd,
                      output logic o_busy, output bit e_err, output logic [31:0] e_rd,
                      output int lat, output int nbusy, output int extra);
    req3 = 1'b1; we3 = we; sz3 = sz; sg3 = sg; adr3 = a; wd3 = wd;
    model(1, we, sz, sg, a, wd, e_err, e_rd);
    @(posedge CLK); #1;
    lat = 0; nbusy = 0; extra = 0;
    for (int i = 1; i <= 12; i++) begin
      if (busy3 === 1'b1) nbusy++;
      if (pulse && i == 2) begin
        req3 = 1'b1; we3 = 1'b1; sz3 = 2'b10; adr3 = pa; wd3 = 32'hBAD0BAD0;
      end else req3 = 1'b0;
      @(posedge CLK); #1;
      if (ack3 === 1'b1) begin lat = i + 1; break; end
    end
    req3 = 1'b0;
    o_ack = ack3; o_err = err3; o_rd = rd3; o_busy = busy3;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if (ack3 !== 1'b0) extra++;
    end
  endtask

  task automatic test_reset();
    logic a, e; logic [31:0] r, er; bit ee;
    rst0_n = 1'b1; rst3_n = 1'b1;
    req0 = 0; we0 = 0; sz0 = 0; sg0 = 0; adr0 = 0; wd0 = 0;
    req3 = 0; we3 = 0; sz3 = 0; sg3 = 0; adr3 = 0; wd3 = 0;
    #1 rst0_n = 1'b0; rst3_n = 1'b0;
    #1;
    checks++; if ({ack0, err0, busy0} !== 3'b000) begin failures++; $display("FAIL rst0_flags got=%b exp=000", {ack0, err0, busy0}); end
    checks++; if (rd0 !== 32'd0) begin failures++; $display("FAIL rst0_rdata got=%h exp=0", rd0); end
    checks++; if ({ack3, err3, busy3} !== 3'b000) begin failures++; $display("FAIL rst3_flags got=%b exp=000", {ack3, err3, busy3}); end
    checks++; if (rd3 !== 32'd0) begin failures++; $display("FAIL rst3_rdata got=%h exp=0", rd3); end
    #10 rst0_n = 1'b1; rst3_n = 1'b1;
    @(posedge CLK); #1;
    acc0(0, 2'b10, 0, 16'h0, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || e !== ee || r !== er || r !== 32'h0) begin failures++; $display("FAIL load0_after_rst ack=%b err=%b rd=%h exp ack=1 err=0 rd=00000000", a, e, r); end
    idle0(a);
  endtask

  task automatic test_word();
    logic a, e; logic [31:0] r, er; bit ee;
    acc0(1, 2'b10, 0, 16'h10, 32'hDEADBEEF, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || e !== 1'b0 || r !== 32'h0) begin failures++; $display("FAIL word_store ack=%b err=%b rd=%h exp ack=1 err=0 rd=0", a, e, r); end
    idle0(a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL word_idle_ack got=%b exp=0", a); end
    acc0(0, 2'b10, 0, 16'h10, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || e !== 1'b0 || r !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load ack=%b err=%b rd=%h exp ack=1 err=0 rd=deadbeef", a, e, r); end
    idle0(a);
    checks++; if (r !== rd0) begin failures++; $display("FAIL rdata_hold got=%h exp=%h", rd0, r); end
  endtask

  task automatic test_back_to_back();
    logic a, e; logic [31:0] r, er; bit ee;
    acc0(0, 2'b10, 0, 16'h10, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || r !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_first ack=%b rd=%h exp ack=1 rd=deadbeef", a, r); end
    acc0(0, 2'b10, 0, 16'h0, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL b2b_second ack=%b rd=%h exp ack=1 rd=0", a, r); end
    idle0(a);
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL b2b_idle_ack got=%b exp=0", a); end
  endtask

  task automatic test_byte_half();
    logic a, e; logic [31:0] r, er; bit ee;
    acc0(1, 2'b10, 0, 16'h20, 32'h11223344, a, e, r, ee, er);
    acc0(1, 2'b00, 0, 16'h21, 32'hFFFFFFAA, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || e !== 1'b0 || r !== 32'h0) begin failures++; $display("FAIL byte_store ack=%b err=%b rd=%h exp ack=1 err=0 rd=0", a, e, r); end
    acc0(1, 2'b01, 0, 16'h22, 32'hFFFF5566, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL half_store ack=%b err=%b exp ack=1 err=0", a, e); end
    acc0(0, 2'b10, 0, 16'h20, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || e !== 1'b0 || r !== 32'h5566AA44 || r !== er) begin failures++; $display("FAIL byte_half_merge ack=%b err=%b rd=%h exp rd=5566aa44", a, e, r); end
    idle0(a);
  endtask

  task automatic test_extension();
    logic a, e; logic [31:0] r, er; bit ee;
    acc0(1, 2'b10, 0, 16'h30, 32'h0080FF7F, a, e, r, ee, er);
    acc0(0, 2'b00, 1, 16'h31, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || r !== 32'hFFFFFFFF) begin failures++; $display("FAIL sbyte_31 ack=%b rd=%h exp=ffffffff", a, r); end
    acc0(0, 2'b00, 0, 16'h31, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || r !== 32'h000000FF) begin failures++; $display("FAIL ubyte_31 ack=%b rd=%h exp=000000ff", a, r); end
    acc0(0, 2'b01, 1, 16'h32, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || r !== 32'h00000080) begin failures++; $display("FAIL shalf_32 ack=%b rd=%h exp=00000080", a, r); end
    acc0(0, 2'b00, 1, 16'h30, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || r !== 32'h0000007F) begin failures++; $display("FAIL sbyte_30 ack=%b rd=%h exp=0000007f", a, r); end
    acc0(0, 2'b01, 1, 16'h30, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || r !== 32'hFFFFFF7F) begin failures++; $display("FAIL shalf_30 ack=%b rd=%h exp=ffffff7f", a, r); end
    idle0(a);
  endtask

  task automatic test_errors();
    logic a, e; logic [31:0] r, er; bit ee;
    acc0(0, 2'b10, 0, 16'h32, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL err_word_mis ack=%b err=%b rd=%h exp 1 1 0", a, e, r); end
    acc0(1, 2'b01, 0, 16'h33, 32'h0000FFFF, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL err_half_mis ack=%b err=%b rd=%h exp 1 1 0", a, e, r); end
    acc0(1, 2'b11, 0, 16'h30, 32'hFFFFFFFF, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL err_size11 ack=%b err=%b rd=%h exp 1 1 0", a, e, r); end
    acc0(0, 2'b10, 0, 16'(4*DEPTH), 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL err_range_ld ack=%b err=%b rd=%h exp 1 1 0", a, e, r); end
    acc0(1, 2'b10, 0, 16'(4*DEPTH), 32'h13579BDF, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL err_range_st ack=%b err=%b rd=%h exp 1 1 0", a, e, r); end
    acc0(0, 2'b10, 0, 16'h30, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || e !== 1'b0 || r !== 32'h0080FF7F) begin failures++; $display("FAIL err_target_kept ack=%b err=%b rd=%h exp rd=0080ff7f", a, e, r); end
    acc0(0, 2'b10, 0, 16'h0, 0, a, e, r, ee, er);
    checks++; if (a !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL err_word0_kept rd=%h exp=0", r); end
    idle0(a);
    checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL err_idle got=%b exp=0", err0); end
  endtask

  task automatic test_reset_mid();
    logic a, e; logic [31:0] r, er; bit ee;
    acc0(0, 2'b10, 0, 16'h20, 0, a, e, r, ee, er);
    rst0_n = 1'b0;
    #1;
    checks++; if ({ack0, err0, busy0} !== 3'b000 || rd0 !== 32'h0) begin failures++; $display("FAIL rst_mid flags=%b rd=%h exp 000 0", {ack0, err0, busy0}, rd0); end
    req0 = 1'b0;
    #2 rst0_n = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_random0();
    logic a, e, ai; logic [31:0] r, er; bit ee;
    for (int n = 0; n < 200; n++) begin
      acc0(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 4*DEPTH + 7)), $urandom, a, e, r, ee, er);
      checks++; if (a !== 1'b1 || e !== ee || r !== er) begin failures++; $display("FAIL rand0[%0d] ack=%b err=%b rd=%h exp ack=1 err=%b rd=%h", n, a, e, r, ee, er); end
      if ($urandom_range(0, 3) == 0) begin
        idle0(ai);
        checks++; if (ai !== 1'b0) begin failures++; $display("FAIL rand0_idle[%0d] ack=%b exp=0", n, ai); end
      end
    end
    idle0(a);
  endtask

  task automatic test_wait();
    logic a, e, b; logic [31:0] r, er; bit ee; int lat, nb, ex;
    acc3(1, 2'b10, 0, 16'h8, 32'hA5A55A5A, 0, 16'h0, a, e, r, b, ee, er, lat, nb, ex);
    checks++; if (lat !== 4) begin failures++; $display("FAIL wait_latency got=%0d exp=4", lat); end
    checks++; if (nb !== 3) begin failures++; $display("FAIL wait_busy_cycles got=%0d exp=3", nb); end
    checks++; if (a !== 1'b1 || e !== 1'b0 || r !== 32'h0 || b !== 1'b0) begin failures++; $display("FAIL wait_store ack=%b err=%b rd=%h busy=%b exp 1 0 0 0", a, e, r, b); end
    acc3(0, 2'b10, 0, 16'h8, 0, 1, 16'h8, a, e, r, b, ee, er, lat, nb, ex);
    checks++; if (ex !== 0) begin failures++; $display("FAIL wait_req_ignored extra_acks=%0d exp=0", ex); end
    checks++; if (lat !== 4 || a !== 1'b1 || r !== 32'hA5A55A5A) begin failures++; $display("FAIL wait_load lat=%0d ack=%b rd=%h exp 4 1 a5a55a5a", lat, a, r); end
    acc3(0, 2'b10, 0, 16'h8, 0, 0, 16'h0, a, e, r, b, ee, er, lat, nb, ex);
    checks++; if (a !== 1'b1 || r !== 32'hA5A55A5A) begin failures++; $display("FAIL wait_pulse_nowrite ack=%b rd=%h exp=a5a55a5a", a, r); end
  endtask

  task automatic test_wait_reset();
    logic a, e, b; logic [31:0] r, er; bit ee; int lat, nb, ex;
    acc3(1, 2'b10, 0, 16'h40, 32'h12345678, 0, 16'h0, a, e, r, b, ee, er, lat, nb, ex);
    acc3(0, 2'b10, 0, 16'h40, 0, 0, 16'h0, a, e, r, b, ee, er, lat, nb, ex);
    checks++; if (r !== 32'h12345678) begin failures++; $display("FAIL wrst_preload rd=%h exp=12345678", r); end
    req3 = 1'b1; we3 = 1'b1; sz3 = 2'b10; sg3 = 1'b0; adr3 = 16'h40; wd3 = 32'hCAFEF00D;
    @(posedge CLK); #1;
    req3 = 1'b0;
    @(posedge CLK); #1;
    checks++; if (busy3 !== 1'b1) begin failures++; $display("FAIL wrst_busy_before got=%b exp=1", busy3); end
    rst3_n = 1'b0;
    #1;
    checks++; if ({ack3, err3, busy3} !== 3'b000 || rd3 !== 32'h0) begin failures++; $display("FAIL wrst_async flags=%b rd=%h exp 000 0", {ack3, err3, busy3}, rd3); end
    #2 rst3_n = 1'b1;
    @(posedge CLK); #1;
    acc3(0, 2'b10, 0, 16'h40, 0, 0, 16'h0, a, e, r, b, ee, er, lat, nb, ex);
    checks++; if (a !== 1'b1 || r !== 32'h12345678 || r !== er) begin failures++; $display("FAIL wrst_discarded ack=%b rd=%h exp=12345678", a, r); end
  endtask

  task automatic test_random3();
    logic a, e, b; logic [31:0] r, er; bit ee; int lat, nb, ex;
    for (int n = 0; n < 15; n++) begin
      acc3(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 4*DEPTH + 7)), $urandom, 0, 16'h0, a, e, r, b, ee, er, lat, nb, ex);
      checks++; if (lat !== 4 || a !== 1'b1 || e !== ee || r !== er || ex !== 0) begin failures++; $display("FAIL rand3[%0d] lat=%0d ack=%b err=%b rd=%h extra=%0d exp 4 1 %b %h 0", n, lat, a, e, r, ex, ee, er); end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4*DEPTH; i++) mb[d][i] = 8'h00;
    test_reset();
    test_word();
    test_back_to_back();
    test_byte_half();
    test_extension();
    test_errors();
    test_reset_mid();
    test_random0();
    test_wait();
    test_wait_reset();
    test_random3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/dmem_bus.md
Name: dmem_bus

Overview:
- Parametrised MIPS data memory: successor to the single-cycle word-only data memory.
- Adds byte/halfword/word stores and loads, sign/zero extension, misalignment and range error reporting, and a REQ/ACK handshake with configurable wait states.
- Sits between the MEM stage (or a cache/bus adapter) and on-chip data RAM.

Parameters:
- ADDR_W, 32, byte-address width of ADR.
- DEPTH, 1024, number of 32-bit words; the index is ADR[ADDR_W-1:2].
- WAIT_CYCLES, 0, extra cycles between request accept and ACK (legal range 0..15).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  1  access request; sampled only when BUSY=0.
- WE  in  1  1=store, 0=load; sampled with REQ.
- SIZE  in  2  00=byte, 01=half, 10=word, 11=reserved.
- SIGNED  in  1  load extension: 1=sign-extend, 0=zero-extend; ignored on stores.
- ADR  in  ADDR_W  byte address.
- WDATA  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- ACK  out  1  one-cycle completion pulse.
- RDATA  out  32  load result, valid while ACK=1.
- ERR  out  1  error flag, valid only while ACK=1.
- BUSY  out  1  1 while an accepted access is pending.

Behaviour:
- Reset (RST_N low, asynchronous): ACK=0, ERR=0, RDATA=0, BUSY=0, FSM=IDLE, wait counter=0. RAM contents are not cleared. Simulation initialises every word to 0.
- Reset during WAIT: the pending access is discarded; no RAM write occurs.
- All outputs are registered.
- FSM states: IDLE, WAIT.
- Accept: at a rising edge with FSM=IDLE and REQ=1, capture WE, SIZE, SIGNED, ADR and WDATA. REQ need not be held after accept.
- WAIT_CYCLES=0: the access executes at the accept edge; ACK=1 in the following cycle; FSM stays IDLE. REQ held high gives one ACK per cycle.
- WAIT_CYCLES=N>0: at accept, FSM goes to WAIT, counter=N-1, BUSY=1.
  - In WAIT, the counter decrements each edge.
  - At the edge where the counter is 0, the access executes, ACK=1 next cycle, FSM goes to IDLE, BUSY=0.
  - Accept-to-ACK latency is N+1 edges.
  - REQ is ignored while BUSY=1.
- ACK is 0 in every cycle without a completion.
- RDATA holds its last value between ACKs.
- Error: ERR=1 with ACK in any of these cases:
  - SIZE=11;
  - SIZE=01 and ADR[0]=1;
  - SIZE=10 and ADR[1:0]!=0;
  - word index >= DEPTH.
  - On error: no RAM write and RDATA=0.
- Byte lanes are little-endian: lane = ADR[1:0], byte b occupies bits [8b+7:8b].
  - Byte store writes WDATA[7:0] to the addressed lane only.
  - Half store writes WDATA[15:0] to bits [15:0] if ADR[1]=0, else to [31:16].
  - Word store writes all 32 bits.
  - Unaddressed lanes are preserved.
- Loads extract the addressed byte/half, right-align it, then sign- or zero-extend per SIGNED. A word load returns the word unchanged.
- Store completion: ACK=1, ERR=0, RDATA=0.
- A load that immediately follows a store to the same word returns the new data; no bypass hazard exists because accesses are serialised.

Test Plan:
- Reset/idle: RST_N low mid-operation → ACK=0, RDATA=0, BUSY=0 immediately, without waiting for a clock. Word load from 0x0 after reset → RDATA=0x00000000.
- Word path, WAIT_CYCLES=0: store 0xDEADBEEF to 0x10, then load 0x10 → ACK one cycle after each accept, RDATA=0xDEADBEEF. Two back-to-back loads → two consecutive ACK pulses.
- Byte/half stores: word 0x11223344 at 0x20; byte store 0xAA to 0x21; half store 0x5566 to 0x22 → word load 0x20 returns 0x5566AA44.
- Extension: word 0x0080FF7F at 0x30.
  - Signed byte load 0x31 → 0xFFFFFFFF; unsigned → 0x000000FF.
  - Signed half load 0x32 → 0x00000080.
  - Signed byte load 0x30 → 0x0000007F.
- Errors: word load 0x32, half store 0x33, SIZE=11, and address 4*DEPTH → each gives ACK=1, ERR=1, RDATA=0. A following load of the target word shows it unchanged.
- Wait states, WAIT_CYCLES=3:
  - ACK arrives 4 edges after accept; BUSY=1 for 3 cycles.
  - A REQ pulse during BUSY is ignored (no extra ACK).
  - RST_N pulsed low during WAIT of a store → the stored word is unchanged.
